mips_mc_ctrl: RTL and testbench
===============================

# mips_mc_ctrl

Multi-cycle control unit for the next-generation MIPS core. It replaces the single-cycle combinational decode with a state machine, so one shared memory port and one ALU serve fetch, address calculation and execute. Memory access uses a req/ready handshake with variable latency and a timeout fault. The block sits between the instruction register's opcode field and the datapath enables: PC, IR, RF, memory and the ALU source/op muxes.

## Interface
- `TIMEOUT`, default 16: maximum number of cycles `mem_req` may wait for `mem_ready` before a fault is raised (≥1).
- `CNT_W`, default 32: width of the retired-instruction counter.
- `HAS_JAL`, default 1: when 0, opcode `jal` is illegal.

- `clk` input, 1 bit: the single clock.
- `rst` input, 1 bit: asynchronous, active-low reset.
- `op` input, 6 bits: instruction[31:26], read from the IR.
- `zero` input, 1 bit: ALU zero flag.
- `mem_ready` input, 1 bit: memory completes the current access.
- `mem_req` output, 1 bit: memory access request.
- `mem_we` output, 1 bit: access is a write.
- `i_or_d` output, 1 bit: memory address source, 0 = PC, 1 = ALUOut.
- `ir_we` output, 1 bit: load the IR.
- `pc_we` output, 1 bit: load the PC.
- `pc_src` output, 2 bits: next-PC source, 0 = ALU (PC+4), 1 = ALUOut (branch target), 2 = jump target.
- `reg_we` output, 1 bit: register-file write.
- `reg_dst` output, 2 bits: write-register select, 0 = rt, 1 = rd, 2 = $31.
- `wb_sel` output, 2 bits: write-back data select, 0 = ALUOut, 1 = MDR, 2 = PC.
- `alu_src_a` output, 1 bit: ALU A input, 0 = PC, 1 = rs.
- `alu_src_b` output, 2 bits: ALU B input, 0 = rt, 1 = constant 4, 2 = sign-extended imm, 3 = sign-extended imm<<2.
- `alu_op` output, 2 bits: 0 = add, 1 = sub, 2 = funct-decoded, 3 = or.
- `fault` output, 1 bit: sticky fault (illegal opcode or memory timeout).
- `instr_cnt` output, `CNT_W` bits: number of retired instructions.
- `state` output, 4 bits: current state encoding, for debug.

## Operation
- Decoded opcodes:
  - R-type = 000000
  - lw = 100011
  - sw = 101011
  - beq = 000100
  - bne = 000101
  - addi = 001000
  - ori = 001101
  - j = 000010
  - jal = 000011
  - Any other opcode, and jal when `HAS_JAL`=0, goes to FAULT.
- All outputs are Moore outputs (depend on state only), except `pc_we` in BRANCH and the handshake-qualified strobes in FETCH and MEMRD.
- Outputs not listed for a state are 0.
- FETCH: `mem_req`=1, `i_or_d`=0, `alu_src_a`=0, `alu_src_b`=1, `alu_op`=0, `pc_src`=0.
  - When `mem_ready`=1: `ir_we`=1, `pc_we`=1, go to DECODE.
- DECODE: `alu_src_a`=0, `alu_src_b`=3, `alu_op`=0 (computes the branch target). Next state by opcode:
  - lw/sw → MEMADR
  - R-type → EXEC
  - addi/ori → IEXEC
  - beq/bne → BRANCH
  - j → JUMP
  - jal → JAL
  - illegal → FAULT
- MEMADR: `alu_src_a`=1, `alu_src_b`=2, `alu_op`=0. Next: MEMRD (lw) or MEMWR (sw).
- MEMRD: `mem_req`=1, `i_or_d`=1. When `mem_ready`=1, go to MEMWB.
- MEMWB: `reg_we`=1, `reg_dst`=0, `wb_sel`=1 → FETCH.
- MEMWR: `mem_req`=1, `mem_we`=1, `i_or_d`=1. When `mem_ready`=1, go to FETCH.
- EXEC: `alu_src_a`=1, `alu_src_b`=0, `alu_op`=2 → ALUWB.
- ALUWB: `reg_we`=1, `reg_dst`=1, `wb_sel`=0 → FETCH.
- IEXEC: `alu_src_a`=1, `alu_src_b`=2, `alu_op`=0 (addi) or 3 (ori) → IWB.
- IWB: `reg_we`=1, `reg_dst`=0, `wb_sel`=0 → FETCH.
- BRANCH: `alu_src_a`=1, `alu_src_b`=0, `alu_op`=1, `pc_src`=1.
  - `pc_we` = `zero` for beq, `~zero` for bne.
  - → FETCH.
- JUMP: `pc_we`=1, `pc_src`=2 → FETCH.
- JAL: `pc_we`=1, `pc_src`=2, `reg_we`=1, `reg_dst`=2, `wb_sel`=2 (the PC already holds PC+4) → FETCH.
- FAULT: absorbing state. All strobes are 0 and `fault`=1 until reset.
- Wait counter:
  - Clears on entry to any memory state.
  - Increments each cycle `mem_req`=1 and `mem_ready`=0.
  - When it reaches `TIMEOUT` with `mem_ready` still 0, go to FAULT on the next edge.
  - `mem_ready` arriving on the same cycle the counter hits `TIMEOUT` wins: the access completes normally.
- `mem_ready` is ignored while `mem_req`=0.
- `instr_cnt` increments by 1 on every transition into FETCH from a terminal state (MEMWB, MEMWR, ALUWB, IWB, BRANCH, JUMP, JAL). It wraps modulo 2^`CNT_W`. Reset exit does not count.

## Timing
- Reset (`rst`=0, asynchronous): `state`=FETCH, `instr_cnt`=0, `fault`=0, wait counter=0.
  - All strobes read as FETCH values with `mem_ready` treated as 0: `mem_req` is held at 0 while `rst`=0 and the only nonzero output is `alu_src_b`=1.
- Reset asserted mid-access aborts the access immediately. No write strobe survives the reset edge.
- Cycles per instruction with zero-wait memory (`mem_ready`=1 in the first request cycle):
  - lw 5
  - sw 4
  - R-type 4
  - addi/ori 4
  - beq/bne 3
  - j 3
  - jal 3
- Each wait cycle on a memory access adds 1 cycle.
- `pc_we` and `ir_we` in FETCH are asserted only in the `mem_ready` cycle.

## Test plan
- Reset, then R-type with `mem_ready` tied 1: states FETCH→DECODE→EXEC→ALUWB→FETCH. `reg_we`=1 with `reg_dst`=1 in cycle 4. `instr_cnt`=1 after cycle 4.
- lw with a 3-cycle memory wait on both fetch and read: total 5+3+3=11 cycles. `ir_we` pulses exactly once. `reg_we`/`wb_sel`=1 in MEMWB.
- beq with `zero`=1 → `pc_we`=1, `pc_src`=1 in BRANCH. Repeat with `zero`=0 → `pc_we`=0. bne gives the inverse of each.
- jal with `HAS_JAL`=1: `reg_dst`=2, `wb_sel`=2, `pc_src`=2 in the same cycle. With `HAS_JAL`=0, or op=111111: FAULT after DECODE, `fault`=1, no further `mem_req`.
- `TIMEOUT`=4 with `mem_ready` held 0: FAULT on the 5th cycle. With `mem_ready`=1 exactly at count 4: completes normally.
- Assert `rst` during MEMWR with `mem_req`=1: outputs return to reset values asynchronously. After release, `instr_cnt`=0 and a normal fetch proceeds. `CNT_W`=2: 5 instructions → `instr_cnt`=1.

Source files
------------

// File: rtl/mips_mc_ctrl.sv
// Multi-cycle MIPS control unit: a Moore FSM that sequences one shared memory
// port and one ALU through fetch, decode, address, execute and write-back.
// Memory accesses use a req/ready handshake guarded by a wait-cycle timeout.
module mips_mc_ctrl #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 32,
    parameter bit          HAS_JAL = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       op,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             i_or_d,
    output logic             ir_we,
    output logic             pc_we,
    output logic [1:0]       pc_src,
    output logic             reg_we,
    output logic [1:0]       reg_dst,
    output logic [1:0]       wb_sel,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic             fault,
    output logic [CNT_W-1:0] instr_cnt,
    output logic [3:0]       state
);

    localparam int unsigned WAIT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    // State encodings (visible on the debug port)
    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEMRD  = 4'd3;
    localparam logic [3:0] S_MEMWB  = 4'd4;
    localparam logic [3:0] S_MEMWR  = 4'd5;
    localparam logic [3:0] S_EXEC   = 4'd6;
    localparam logic [3:0] S_ALUWB  = 4'd7;
    localparam logic [3:0] S_IEXEC  = 4'd8;
    localparam logic [3:0] S_IWB    = 4'd9;
    localparam logic [3:0] S_BRANCH = 4'd10;
    localparam logic [3:0] S_JUMP   = 4'd11;
    localparam logic [3:0] S_JAL    = 4'd12;
    localparam logic [3:0] S_FAULT  = 4'd13;

    // Opcodes
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    logic [3:0]        r_state;
    logic [3:0]        w_next;
    logic [WAIT_W-1:0] r_wait;
    logic [CNT_W-1:0]  r_instr_cnt;
    logic              w_ready;
    logic              w_mem_req;
    logic              w_timeout;
    logic              w_terminal;

    // Handshake is only meaningful while out of reset and requesting
    assign w_ready   = mem_ready & rst & w_mem_req;
    assign w_timeout = (r_wait == WAIT_W'(TIMEOUT));

    // Memory states raise a request; held low while reset is asserted
    assign w_mem_req = rst & ((r_state == S_FETCH) ||
                              (r_state == S_MEMRD) ||
                              (r_state == S_MEMWR));

    // States that retire an instruction on their way back to FETCH
    assign w_terminal = (r_state == S_MEMWB)  || (r_state == S_MEMWR) ||
                        (r_state == S_ALUWB)  || (r_state == S_IWB)   ||
                        (r_state == S_BRANCH) || (r_state == S_JUMP)  ||
                        (r_state == S_JAL);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH: begin
                if (w_ready) begin
                    w_next = S_DECODE;
                end else if (w_timeout) begin
                    w_next = S_FAULT;
                end
            end
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW:    w_next = S_MEMADR;
                    OP_RTYPE:        w_next = S_EXEC;
                    OP_ADDI, OP_ORI: w_next = S_IEXEC;
                    OP_BEQ, OP_BNE:  w_next = S_BRANCH;
                    OP_J:            w_next = S_JUMP;
                    OP_JAL:          w_next = HAS_JAL ? S_JAL : S_FAULT;
                    default:         w_next = S_FAULT;
                endcase
            end
            S_MEMADR: begin
                w_next = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                if (w_ready) begin
                    w_next = S_MEMWB;
                end else if (w_timeout) begin
                    w_next = S_FAULT;
                end
            end
            S_MEMWR: begin
                if (w_ready) begin
                    w_next = S_FETCH;
                end else if (w_timeout) begin
                    w_next = S_FAULT;
                end
            end
            S_MEMWB:  w_next = S_FETCH;
            S_EXEC:   w_next = S_ALUWB;
            S_ALUWB:  w_next = S_FETCH;
            S_IEXEC:  w_next = S_IWB;
            S_IWB:    w_next = S_FETCH;
            S_BRANCH: w_next = S_FETCH;
            S_JUMP:   w_next = S_FETCH;
            S_JAL:    w_next = S_FETCH;
            S_FAULT:  w_next = S_FAULT;
            default:  w_next = S_FAULT;
        endcase
    end

    // Datapath control decode: Moore per state, plus handshake and branch qualifiers
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        i_or_d    = 1'b0;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        pc_src    = 2'd0;
        reg_we    = 1'b0;
        reg_dst   = 2'd0;
        wb_sel    = 2'd0;
        alu_src_a = 1'b0;
        alu_src_b = 2'd0;
        alu_op    = 2'd0;
        fault     = 1'b0;
        case (r_state)
            S_FETCH: begin
                mem_req   = w_mem_req;
                alu_src_b = 2'd1;
                ir_we     = w_ready;
                pc_we     = w_ready;
            end
            S_DECODE: begin
                alu_src_b = 2'd3;
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd2;
            end
            S_MEMRD: begin
                mem_req = w_mem_req;
                i_or_d  = 1'b1;
            end
            S_MEMWB: begin
                reg_we = 1'b1;
                wb_sel = 2'd1;
            end
            S_MEMWR: begin
                mem_req = w_mem_req;
                mem_we  = w_mem_req;
                i_or_d  = 1'b1;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'd2;
            end
            S_ALUWB: begin
                reg_we  = 1'b1;
                reg_dst = 2'd1;
            end
            S_IEXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd2;
                alu_op    = (op == OP_ORI) ? 2'd3 : 2'd0;
            end
            S_IWB: begin
                reg_we = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = 2'd1;
                pc_src    = 2'd1;
                pc_we     = (op == OP_BEQ) ? zero : ~zero;
            end
            S_JUMP: begin
                pc_we  = 1'b1;
                pc_src = 2'd2;
            end
            S_JAL: begin
                pc_we   = 1'b1;
                pc_src  = 2'd2;
                reg_we  = 1'b1;
                reg_dst = 2'd2;
                wb_sel  = 2'd2;
            end
            S_FAULT: begin
                fault = 1'b1;
            end
            default: begin
                fault = 1'b1;
            end
        endcase
    end

    // Wait counter: restarts on every state change, counts unanswered request cycles
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wait <= '0;
        end else if (w_next != r_state) begin
            r_wait <= '0;
        end else if (w_mem_req && !mem_ready && !w_timeout) begin
            r_wait <= r_wait + WAIT_W'(1);
        end
    end

    // Retired-instruction counter, wraps naturally at its width
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_instr_cnt <= '0;
        end else if (w_terminal && (w_next == S_FETCH)) begin
            r_instr_cnt <= r_instr_cnt + CNT_W'(1);
        end
    end

    assign instr_cnt = r_instr_cnt;
    assign state     = r_state;

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Bench for mips_mc_ctrl: per-cycle vector table on a TIMEOUT=4 / CNT_W=2
// instance, plus hand-written sequences for async reset and the no-jal build.
module tb_mips_mc_ctrl;

    localparam logic [5:0] OP_R   = 6'h00;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_SW  = 6'h2B;
    localparam logic [5:0] OP_BEQ = 6'h04;
    localparam logic [5:0] OP_BNE = 6'h05;
    localparam logic [5:0] OP_ADI = 6'h08;
    localparam logic [5:0] OP_ORI = 6'h0D;
    localparam logic [5:0] OP_J   = 6'h02;
    localparam logic [5:0] OP_JAL = 6'h03;
    localparam logic [5:0] OP_BAD = 6'h3F;

    localparam logic [3:0] S_F   = 4'd0;
    localparam logic [3:0] S_D   = 4'd1;
    localparam logic [3:0] S_MA  = 4'd2;
    localparam logic [3:0] S_MR  = 4'd3;
    localparam logic [3:0] S_MWB = 4'd4;
    localparam logic [3:0] S_MW  = 4'd5;
    localparam logic [3:0] S_EX  = 4'd6;
    localparam logic [3:0] S_AWB = 4'd7;
    localparam logic [3:0] S_IE  = 4'd8;
    localparam logic [3:0] S_IWB = 4'd9;
    localparam logic [3:0] S_BR  = 4'd10;
    localparam logic [3:0] S_JP  = 4'd11;
    localparam logic [3:0] S_JL  = 4'd12;
    localparam logic [3:0] S_FL  = 4'd13;

    typedef struct {
        logic        rst;
        logic [5:0]  op;
        logic        zero;
        logic        rdy;
        logic [3:0]  st;
        logic [17:0] ctl;
        logic [1:0]  cnt;
    } vec_t;

    logic        clk;
    logic        rst;
    logic [5:0]  op;
    logic        zero;
    logic        mem_ready;

    logic        mem_req, mem_we, i_or_d, ir_we, pc_we, reg_we, alu_src_a, fault;
    logic [1:0]  pc_src, reg_dst, wb_sel, alu_src_b, alu_op;
    logic [1:0]  instr_cnt;
    logic [3:0]  state;

    logic        nj_mem_req, nj_mem_we, nj_i_or_d, nj_ir_we, nj_pc_we, nj_reg_we, nj_alu_src_a, nj_fault;
    logic [1:0]  nj_pc_src, nj_reg_dst, nj_wb_sel, nj_alu_src_b, nj_alu_op;
    logic [31:0] nj_instr_cnt;
    logic [3:0]  nj_state;

    logic [17:0] w_ctl;

    int checks   = 0;
    int failures = 0;
    vec_t tbl[$];

    logic [17:0] K_RST, K_FW, K_FR, K_DEC, K_MADR, K_MRD, K_MWB, K_MWR, K_EXE;
    logic [17:0] K_AWB, K_IADD, K_IOR, K_IWB, K_BT, K_BN, K_JMP, K_JAL, K_FLT;

    assign w_ctl = {mem_req, mem_we, i_or_d, ir_we, pc_we, pc_src, reg_we,
                    reg_dst, wb_sel, alu_src_a, alu_src_b, alu_op, fault};

    mips_mc_ctrl #(.TIMEOUT(4), .CNT_W(2), .HAS_JAL(1'b1)) u_dut (
        .clk(clk), .rst(rst), .op(op), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .i_or_d(i_or_d), .ir_we(ir_we),
        .pc_we(pc_we), .pc_src(pc_src), .reg_we(reg_we), .reg_dst(reg_dst),
        .wb_sel(wb_sel), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .fault(fault), .instr_cnt(instr_cnt), .state(state)
    );

    mips_mc_ctrl #(.HAS_JAL(1'b0)) u_nojal (
        .clk(clk), .rst(rst), .op(op), .zero(zero), .mem_ready(mem_ready),
        .mem_req(nj_mem_req), .mem_we(nj_mem_we), .i_or_d(nj_i_or_d), .ir_we(nj_ir_we),
        .pc_we(nj_pc_we), .pc_src(nj_pc_src), .reg_we(nj_reg_we), .reg_dst(nj_reg_dst),
        .wb_sel(nj_wb_sel), .alu_src_a(nj_alu_src_a), .alu_src_b(nj_alu_src_b),
        .alu_op(nj_alu_op), .fault(nj_fault), .instr_cnt(nj_instr_cnt), .state(nj_state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [17:0] mk(input logic mreq, input logic mwe, input logic iord,
                                       input logic irwe, input logic pcwe, input logic [1:0] pcsrc,
                                       input logic regwe, input logic [1:0] regdst,
                                       input logic [1:0] wbsel, input logic a,
                                       input logic [1:0] b, input logic [1:0] aop,
                                       input logic flt);
        return {mreq, mwe, iord, irwe, pcwe, pcsrc, regwe, regdst, wbsel, a, b, aop, flt};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic [5:0] o, input logic z, input logic rd,
                       input logic [3:0] st, input logic [17:0] c, input logic [1:0] n);
        vec_t v;
        v.rst = r; v.op = o; v.zero = z; v.rdy = rd; v.st = st; v.ctl = c; v.cnt = n;
        tbl.push_back(v);
    endtask

    // Zero-wait fetch followed by decode
    task automatic add_fd(input logic [5:0] o, input logic z, input logic [1:0] n);
        add(1'b1, o, z, 1'b1, S_F, K_FR, n);
        add(1'b1, o, z, 1'b1, S_D, K_DEC, n);
    endtask

    task automatic step(input logic r, input logic [5:0] o, input logic z, input logic rd);
        @(posedge clk);
        #1;
        rst = r; op = o; zero = z; mem_ready = rd;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b0; op = OP_R; zero = 1'b0; mem_ready = 1'b0;

        K_RST  = mk(1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,1'b0,2'd0,2'd0,1'b0,2'd1,2'd0,1'b0);
        K_FW   = mk(1'b1,1'b0,1'b0,1'b0,1'b0,2'd0,1'b0,2'd0,2'd0,1'b0,2'd1,2'd0,1'b0);
        K_FR   = mk(1'b1,1'b0,1'b0,1'b1,1'b1,2'd0,1'b0,2'd0,2'd0,1'b0,2'd1,2'd0,1'b0);
        K_DEC  = mk(1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,1'b0,2'd0,2'd0,1'b0,2'd3,2'd0,1'b0);
        K_MADR = mk(1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,1'b0,2'd0,2'd0,1'b1,2'd2,2'd0,1'b0);
        K_MRD  = mk(1'b1,1'b0,1'b1,1'b0,1'b0,2'd0,1'b0,2'd0,2'd0,1'b0,2'd0,2'd0,1'b0);
        K_MWB  = mk(1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,1'b1,2'd0,2'd1,1'b0,2'd0,2'd0,1'b0);
        K_MWR  = mk(1'b1,1'b1,1'b1,1'b0,1'b0,2'd0,1'b0,2'd0,2'd0,1'b0,2'd0,2'd0,1'b0);
        K_EXE  = mk(1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,1'b0,2'd0,2'd0,1'b1,2'd0,2'd2,1'b0);
        K_AWB  = mk(1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,1'b1,2'd1,2'd0,1'b0,2'd0,2'd0,1'b0);
        K_IADD = mk(1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,1'b0,2'd0,2'd0,1'b1,2'd2,2'd0,1'b0);
        K_IOR  = mk(1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,1'b0,2'd0,2'd0,1'b1,2'd2,2'd3,1'b0);
        K_IWB  = mk(1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,1'b1,2'd0,2'd0,1'b0,2'd0,2'd0,1'b0);
        K_BT   = mk(1'b0,1'b0,1'b0,1'b0,1'b1,2'd1,1'b0,2'd0,2'd0,1'b1,2'd0,2'd1,1'b0);
        K_BN   = mk(1'b0,1'b0,1'b0,1'b0,1'b0,2'd1,1'b0,2'd0,2'd0,1'b1,2'd0,2'd1,1'b0);
        K_JMP  = mk(1'b0,1'b0,1'b0,1'b0,1'b1,2'd2,1'b0,2'd0,2'd0,1'b0,2'd0,2'd0,1'b0);
        K_JAL  = mk(1'b0,1'b0,1'b0,1'b0,1'b1,2'd2,1'b1,2'd2,2'd2,1'b0,2'd0,2'd0,1'b0);
        K_FLT  = mk(1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,1'b0,2'd0,2'd0,1'b0,2'd0,2'd0,1'b1);

        // Reset: ready is ignored, only alu_src_b=1 visible
        add(1'b0, OP_R, 1'b0, 1'b0, S_F, K_RST, 2'd0);
        add(1'b0, OP_R, 1'b0, 1'b1, S_F, K_RST, 2'd0);
        // R-type, zero-wait: 4 cycles
        add_fd(OP_R, 1'b0, 2'd0);
        add(1'b1, OP_R, 1'b0, 1'b1, S_EX,  K_EXE, 2'd0);
        add(1'b1, OP_R, 1'b0, 1'b1, S_AWB, K_AWB, 2'd0);
        // lw with 3 wait cycles on fetch and on read: 11 cycles
        for (int i = 0; i < 3; i++) add(1'b1, OP_LW, 1'b0, 1'b0, S_F, K_FW, 2'd1);
        add(1'b1, OP_LW, 1'b0, 1'b1, S_F,  K_FR,   2'd1);
        add(1'b1, OP_LW, 1'b0, 1'b1, S_D,  K_DEC,  2'd1);
        add(1'b1, OP_LW, 1'b0, 1'b1, S_MA, K_MADR, 2'd1);
        for (int i = 0; i < 3; i++) add(1'b1, OP_LW, 1'b0, 1'b0, S_MR, K_MRD, 2'd1);
        add(1'b1, OP_LW, 1'b0, 1'b1, S_MR,  K_MRD, 2'd1);
        add(1'b1, OP_LW, 1'b0, 1'b0, S_MWB, K_MWB, 2'd1);
        // sw zero-wait: 4 cycles
        add_fd(OP_SW, 1'b0, 2'd2);
        add(1'b1, OP_SW, 1'b0, 1'b1, S_MA, K_MADR, 2'd2);
        add(1'b1, OP_SW, 1'b0, 1'b1, S_MW, K_MWR,  2'd2);
        // addi, then ori (counter wraps 3 -> 0 after the 4th instruction)
        add_fd(OP_ADI, 1'b0, 2'd3);
        add(1'b1, OP_ADI, 1'b0, 1'b1, S_IE,  K_IADD, 2'd3);
        add(1'b1, OP_ADI, 1'b0, 1'b1, S_IWB, K_IWB,  2'd3);
        add_fd(OP_ORI, 1'b0, 2'd0);
        add(1'b1, OP_ORI, 1'b0, 1'b1, S_IE,  K_IOR, 2'd0);
        add(1'b1, OP_ORI, 1'b0, 1'b1, S_IWB, K_IWB, 2'd0);
        // Branches: beq z=1 taken, beq z=0 not, bne z=1 not, bne z=0 taken
        add_fd(OP_BEQ, 1'b1, 2'd1); add(1'b1, OP_BEQ, 1'b1, 1'b1, S_BR, K_BT, 2'd1);
        add_fd(OP_BEQ, 1'b0, 2'd2); add(1'b1, OP_BEQ, 1'b0, 1'b1, S_BR, K_BN, 2'd2);
        add_fd(OP_BNE, 1'b1, 2'd3); add(1'b1, OP_BNE, 1'b1, 1'b1, S_BR, K_BN, 2'd3);
        add_fd(OP_BNE, 1'b0, 2'd0); add(1'b1, OP_BNE, 1'b0, 1'b1, S_BR, K_BT, 2'd0);
        // j and jal
        add_fd(OP_J,   1'b0, 2'd1); add(1'b1, OP_J,   1'b0, 1'b1, S_JP, K_JMP, 2'd1);
        add_fd(OP_JAL, 1'b0, 2'd2); add(1'b1, OP_JAL, 1'b0, 1'b1, S_JL, K_JAL, 2'd2);
        // sw: ready arrives when the wait counter sits at TIMEOUT=4 -> completes
        for (int i = 0; i < 4; i++) add(1'b1, OP_SW, 1'b0, 1'b0, S_F, K_FW, 2'd3);
        add(1'b1, OP_SW, 1'b0, 1'b1, S_F,  K_FR,   2'd3);
        add(1'b1, OP_SW, 1'b0, 1'b1, S_D,  K_DEC,  2'd3);
        add(1'b1, OP_SW, 1'b0, 1'b1, S_MA, K_MADR, 2'd3);
        add(1'b1, OP_SW, 1'b0, 1'b0, S_MW, K_MWR,  2'd3);
        add(1'b1, OP_SW, 1'b0, 1'b0, S_MW, K_MWR,  2'd3);
        // Reset during MEMWR aborts the write and clears the counter
        add(1'b0, OP_SW, 1'b0, 1'b0, S_F, K_RST, 2'd0);
        add_fd(OP_R, 1'b0, 2'd0);
        add(1'b1, OP_R, 1'b0, 1'b1, S_EX,  K_EXE, 2'd0);
        add(1'b1, OP_R, 1'b0, 1'b1, S_AWB, K_AWB, 2'd0);
        // lw read never answered: counter 0..4 over 5 cycles, then FAULT
        add_fd(OP_LW, 1'b0, 2'd1);
        add(1'b1, OP_LW, 1'b0, 1'b1, S_MA, K_MADR, 2'd1);
        for (int i = 0; i < 5; i++) add(1'b1, OP_LW, 1'b0, 1'b0, S_MR, K_MRD, 2'd1);
        add(1'b1, OP_LW, 1'b0, 1'b0, S_FL, K_FLT, 2'd1);
        add(1'b1, OP_LW, 1'b0, 1'b1, S_FL, K_FLT, 2'd1);
        // Illegal opcode
        add(1'b0, OP_BAD, 1'b0, 1'b0, S_F, K_RST, 2'd0);
        add_fd(OP_BAD, 1'b0, 2'd0);
        add(1'b1, OP_BAD, 1'b0, 1'b1, S_FL, K_FLT, 2'd0);
        add(1'b1, OP_BAD, 1'b0, 1'b1, S_FL, K_FLT, 2'd0);
        // Fetch never answered
        add(1'b0, OP_R, 1'b0, 1'b0, S_F, K_RST, 2'd0);
        for (int i = 0; i < 5; i++) add(1'b1, OP_R, 1'b0, 1'b0, S_F, K_FW, 2'd0);
        add(1'b1, OP_R, 1'b0, 1'b0, S_FL, K_FLT, 2'd0);

        foreach (tbl[i]) begin
            step(tbl[i].rst, tbl[i].op, tbl[i].zero, tbl[i].rdy);
            chk($sformatf("vec%0d state", i), 32'(state), 32'(tbl[i].st));
            chk($sformatf("vec%0d ctl", i), 32'(w_ctl), 32'(tbl[i].ctl));
            chk($sformatf("vec%0d instr_cnt", i), 32'(instr_cnt), 32'(tbl[i].cnt));
        end

        // jal on both builds: the no-jal build faults after DECODE and stops requesting
        step(1'b0, OP_JAL, 1'b0, 1'b0);
        step(1'b1, OP_JAL, 1'b0, 1'b1);
        step(1'b1, OP_JAL, 1'b0, 1'b1);
        step(1'b1, OP_JAL, 1'b0, 1'b1);
        chk("jal state", 32'(state), 32'(S_JL));
        chk("nojal state", 32'(nj_state), 32'(S_FL));
        chk("nojal fault", 32'(nj_fault), 32'd1);
        chk("nojal mem_req", 32'(nj_mem_req), 32'd0);
        step(1'b1, OP_JAL, 1'b0, 1'b1);
        chk("jal retired", 32'(instr_cnt), 32'd1);
        chk("nojal still faulted", 32'(nj_state), 32'(S_FL));
        chk("nojal mem_req held", 32'(nj_mem_req), 32'd0);
        chk("nojal instr_cnt", nj_instr_cnt, 32'd0);

        // Asynchronous reset in the middle of a write cycle
        step(1'b0, OP_SW, 1'b0, 1'b0);
        step(1'b1, OP_SW, 1'b0, 1'b1);
        step(1'b1, OP_SW, 1'b0, 1'b1);
        step(1'b1, OP_SW, 1'b0, 1'b1);
        step(1'b1, OP_SW, 1'b0, 1'b0);
        chk("memwr mem_we", 32'(mem_we), 32'd1);
        chk("memwr mem_req", 32'(mem_req), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("async rst state", 32'(state), 32'(S_F));
        chk("async rst mem_we", 32'(mem_we), 32'd0);
        chk("async rst ctl", 32'(w_ctl), 32'(K_RST));
        step(1'b1, OP_R, 1'b0, 1'b1);
        chk("post-rst ir_we", 32'(ir_we), 32'd1);
        chk("post-rst instr_cnt", 32'(instr_cnt), 32'd0);
        step(1'b1, OP_R, 1'b0, 1'b1);
        chk("post-rst decode", 32'(state), 32'(S_D));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
